vga_pattern_gen: RTL and testbench

//  Pixel-colour stage directly downstream of display_timing, on the same clk100 domain.

---
 rtl/vga_pattern_gen.sv | 161 ++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// Pixel-colour stage behind display_timing: two-stage pipeline producing 12-bit RGB
// and re-timed syncs, with four test patterns including a bouncing square.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SQ_SIZE  = 32,
  parameter logic        SYNC_RST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       enable,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [1:0] mode,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [7:0] frame_cnt
);

  localparam int unsigned BarW = H_ACTIVE / 8;
  localparam logic [9:0]  XLim = 10'(H_ACTIVE - SQ_SIZE);
  localparam logic [9:0]  YLim = 10'(V_ACTIVE - SQ_SIZE);
  localparam logic [9:0]  SqSz = 10'(SQ_SIZE);

  // Stage 1 registers
  logic [9:0]  sx_q, sy_q;
  logic        enable_q, hs_q, vs_q;
  logic        origin_q;

  // Per-frame state
  logic [1:0]  mode_q;
  logic [7:0]  frame_cnt_q;
  logic [9:0]  sqx_q, sqy_q;
  logic        dx_q, dy_q;   // 1 = moving in the + direction

  // Stage 2 registers
  logic [11:0] rgb_q;
  logic        hs_out_q, vs_out_q;

  logic        origin, frame_start;
  logic [10:0] step_x, step_y;
  logic [2:0]  bar_idx;
  logic        in_sq;
  logic [11:0] rgb_d;

  // One bounce step along an axis; returns {new_dir, new_pos}.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir_pos,
                                            input logic [9:0] lim);
    logic [10:0] r;
    if (dir_pos) begin
      r = (pos == lim) ? {1'b0, pos - 10'd1} : {1'b1, pos + 10'd1};
    end else begin
      r = (pos == 10'd0) ? {1'b1, 10'd1} : {1'b0, pos - 10'd1};
    end
    return r;
  endfunction

  // Edge-detect the origin so a pixel spanning several clocks yields one pulse.
  always_comb begin
    origin      = (sx == 10'd0) && (sy == 10'd0);
    frame_start = origin && !origin_q;
    step_x      = step_axis(sqx_q, dx_q, XLim);
    step_y      = step_axis(sqy_q, dy_q, YLim);
  end

  // Stage 1: register the timing inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q     <= '0;
      sy_q     <= '0;
      enable_q <= 1'b0;
      hs_q     <= SYNC_RST;
      vs_q     <= SYNC_RST;
      origin_q <= 1'b0;
    end else begin
      sx_q     <= sx;
      sy_q     <= sy;
      enable_q <= enable;
      hs_q     <= hsync;
      vs_q     <= vsync;
      origin_q <= origin;
    end
  end

  // Frame-rate state: mode latch, frame counter and square motion.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 2'd0;
      frame_cnt_q <= 8'd0;
      sqx_q       <= 10'd0;
      sqy_q       <= 10'd0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
    end else if (frame_start) begin
      mode_q         <= mode;
      frame_cnt_q    <= frame_cnt_q + 8'd1;
      {dx_q, sqx_q}  <= step_x;
      {dy_q, sqy_q}  <= step_y;
    end
  end

  // Bar index by threshold comparison; anything past the last boundary is bar 7.
  always_comb begin
    bar_idx = 3'd7;
    for (int i = 7; i >= 1; i--) begin
      if (sx_q < 10'(BarW * i)) bar_idx = 3'(i - 1);
    end
    in_sq = (sx_q >= sqx_q) && (sx_q < sqx_q + SqSz) &&
            (sy_q >= sqy_q) && (sy_q < sqy_q + SqSz);
  end

  // Colour selection from stage-1 coordinates; blank outside the active area.
  always_comb begin
    rgb_d = 12'h000;
    if (enable_q) begin
      unique case (mode_q)
        2'd0: begin
          unique case (bar_idx)
            3'd0: rgb_d = 12'hFFF;
            3'd1: rgb_d = 12'hFF0;
            3'd2: rgb_d = 12'h0FF;
            3'd3: rgb_d = 12'h0F0;
            3'd4: rgb_d = 12'hF0F;
            3'd5: rgb_d = 12'hF00;
            3'd6: rgb_d = 12'h00F;
            3'd7: rgb_d = 12'h000;
          endcase
        end
        2'd1: rgb_d = (sx_q[5] ^ sy_q[5]) ? 12'hFFF : 12'h000;
        2'd2: rgb_d = in_sq ? 12'hF00 : 12'h002;
        2'd3: rgb_d = {sx_q[9:6], sy_q[8:5], frame_cnt_q[3:0]};
      endcase
    end
  end

  // Stage 2: register colour and the twice-delayed syncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q    <= 12'h000;
      hs_out_q <= SYNC_RST;
      vs_out_q <= SYNC_RST;
    end else begin
      rgb_q    <= rgb_d;
      hs_out_q <= hs_q;
      vs_out_q <= vs_q;
    end
  end

  assign vga_r     = rgb_q[11:8];
  assign vga_g     = rgb_q[7:4];
  assign vga_b     = rgb_q[3:0];
  assign vga_hs    = hs_out_q;
  assign vga_vs    = vs_out_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: a driver feeds compressed frames and pushes
// expected values from a reference model; a monitor pops and compares on their due cycle.
module tb_vga_pattern_gen;

  logic       clk, rst;
  logic [9:0] sx, sy;
  logic       enable, hsync, vsync;
  logic [1:0] mode;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs;
  logic [7:0] frame_cnt;

  vga_pattern_gen dut (
    .clk       (clk),
    .rst       (rst),
    .sx        (sx),
    .sy        (sy),
    .enable    (enable),
    .hsync     (hsync),
    .vsync     (vsync),
    .mode      (mode),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .vga_hs    (vga_hs),
    .vga_vs    (vga_vs),
    .frame_cnt (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [13:0] val;
  } exp_t;

  exp_t pix_q[$];
  exp_t cnt_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int m_mode, m_cnt, m_sqx, m_sqy, m_dx, m_dy;
  bit m_prev_origin;

  function automatic logic [11:0] ref_colour(int md, int x, int y, bit en, int qx, int qy,
                                             int cnt);
    logic [11:0] bars [8];
    int idx;
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    if (!en) return 12'h000;
    case (md)
      0: begin
        idx = x / 80;
        if (idx > 7) idx = 7;
        return bars[idx];
      end
      1: return (((x / 32) + (y / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
      2: return (x >= qx && x < qx + 32 && y >= qy && y < qy + 32) ? 12'hF00 : 12'h002;
      default: return 12'((((x / 64) % 16) * 256) + (((y / 32) % 16) * 16) + (cnt % 16));
    endcase
  endfunction

  // Drive one clock's worth of input and record what must come out of it.
  task automatic drive(input bit r, input int x, input int y, input bit en, input bit h,
                       input bit v, input int md);
    exp_t e;
    bit   origin;
    @(negedge clk);
    rst    = r;
    sx     = 10'(x);
    sy     = 10'(y);
    enable = en;
    hsync  = h;
    vsync  = v;
    mode   = 2'(md);
    if (r) begin
      while (pix_q.size() > 0 && pix_q[pix_q.size()-1].due >= cyc + 1) void'(pix_q.pop_back());
      while (cnt_q.size() > 0 && cnt_q[cnt_q.size()-1].due >= cyc + 1) void'(cnt_q.pop_back());
      m_mode = 0; m_cnt = 0; m_sqx = 0; m_sqy = 0; m_dx = 1; m_dy = 1;
      m_prev_origin = 0;
      e.due = cyc + 1; e.val = {12'h000, 2'b11}; pix_q.push_back(e);
      e.due = cyc + 2; pix_q.push_back(e);
      e.due = cyc + 1; e.val = 14'd0; cnt_q.push_back(e);
    end else begin
      origin = (x == 0 && y == 0);
      if (origin && !m_prev_origin) begin
        m_mode = md;
        m_cnt  = (m_cnt + 1) % 256;
        if (m_dx > 0) begin
          if (m_sqx == 640 - 32) begin m_dx = -1; m_sqx = m_sqx - 1; end
          else m_sqx = m_sqx + 1;
        end else begin
          if (m_sqx == 0) begin m_dx = 1; m_sqx = 1; end
          else m_sqx = m_sqx - 1;
        end
        if (m_dy > 0) begin
          if (m_sqy == 480 - 32) begin m_dy = -1; m_sqy = m_sqy - 1; end
          else m_sqy = m_sqy + 1;
        end else begin
          if (m_sqy == 0) begin m_dy = 1; m_sqy = 1; end
          else m_sqy = m_sqy - 1;
        end
      end
      m_prev_origin = origin;
      e.due = cyc + 2;
      e.val = {ref_colour(m_mode, x, y, en, m_sqx, m_sqy, m_cnt), h, v};
      pix_q.push_back(e);
      e.due = cyc + 1;
      e.val = 14'(m_cnt);
      cnt_q.push_back(e);
    end
  endtask

  // Monitor: compare every entry that falls due this cycle.
  initial begin : monitor
    exp_t e;
    logic [13:0] got;
    forever begin
      @(posedge clk);
      #1;
      while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
        e   = pix_q.pop_front();
        got = {vga_r, vga_g, vga_b, vga_hs, vga_vs};
        total++;
        if (e.due != cyc || got !== e.val) begin
          bad++;
          $display("FAIL pixel cyc=%0d due=%0d got rgb=%h hs/vs=%b want rgb=%h hs/vs=%b",
                   cyc, e.due, got[13:2], got[1:0], e.val[13:2], e.val[1:0]);
        end
      end
      while (cnt_q.size() > 0 && cnt_q[0].due <= cyc) begin
        e = cnt_q.pop_front();
        total++;
        if (e.due != cyc || frame_cnt !== e.val[7:0]) begin
          bad++;
          $display("FAIL frame_cnt cyc=%0d got=%0d want=%0d", cyc, frame_cnt, e.val[7:0]);
        end
      end
    end
  end

  // One compressed frame: origin, square-edge probes, then random pixels.
  task automatic run_frame();
    int md, px[7], py[7], x, y, n;
    bit en;
    md = ($urandom_range(1) == 1) ? 2 : int'($urandom_range(3));
    n  = $urandom_range(3, 1);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1, $urandom_range(1), $urandom_range(1), md);
    px = '{m_sqx - 1, m_sqx, m_sqx + 31, m_sqx + 32, m_sqx, m_sqx, m_sqx};
    py = '{m_sqy, m_sqy, m_sqy, m_sqy, m_sqy - 1, m_sqy + 31, m_sqy + 32};
    for (int i = 0; i < 7; i++) begin
      if (px[i] >= 0 && py[i] >= 0 && !(px[i] == 0 && py[i] == 0))
        drive(0, px[i], py[i], 1, $urandom_range(1), $urandom_range(1), md);
    end
    n = $urandom_range(6, 2);
    for (int i = 0; i < n; i++) begin
      x  = $urandom_range(799);
      y  = $urandom_range(524);
      if (x == 0 && y == 0) x = 1;
      en = (x < 640 && y < 480);
      if ($urandom_range(7) == 0) en = !en;
      if ($urandom_range(5) == 0) md = $urandom_range(3);
      drive(0, x, y, en, $urandom_range(1), $urandom_range(1), md);
    end
  endtask

  initial begin
    rst = 1'b1; sx = '0; sy = '0; enable = 1'b0; hsync = 1'b0; vsync = 1'b0; mode = '0;
    m_mode = 0; m_cnt = 0; m_sqx = 0; m_sqy = 0; m_dx = 1; m_dy = 1; m_prev_origin = 0;

    // Reset held 3 clocks with syncs driven low: outputs must sit at idle values.
    repeat (3) drive(1, 5, 5, 1, 0, 0, 3);

    // First frame in bars mode, then a 3-clock hsync low pulse for latency.
    drive(0, 0, 0, 1, 1, 1, 0);
    repeat (2) drive(0, 10, 0, 1, 1, 1, 0);
    repeat (3) drive(0, 20, 0, 1, 0, 1, 0);
    repeat (2) drive(0, 30, 0, 1, 1, 0, 0);

    // Bar checks: FF0, then last bar 000, then blanked.
    drive(0, 85, 10, 1, 1, 1, 0);
    drive(0, 639, 10, 1, 1, 1, 0);
    drive(0, 85, 10, 0, 1, 1, 0);
    drive(0, 79, 10, 1, 1, 1, 0);
    drive(0, 80, 10, 1, 1, 1, 0);

    // Mode change mid-frame stays bars until the next origin, then checker.
    drive(0, 85, 11, 1, 1, 1, 1);
    drive(0, 0, 0, 1, 1, 1, 1);
    drive(0, 0, 0, 1, 1, 1, 1);
    drive(0, 32, 0, 1, 1, 1, 1);
    drive(0, 31, 0, 1, 1, 1, 1);

    // Long run of compressed frames: covers both bounces and the counter wrap.
    for (int f = 0; f < 1250; f++) run_frame();

    // Reset in the middle of a frame, then resume.
    drive(0, 100, 200, 1, 1, 1, 2);
    drive(0, 101, 200, 1, 1, 1, 2);
    drive(1, 102, 200, 1, 0, 0, 2);
    drive(0, 103, 200, 1, 1, 1, 2);
    drive(0, 104, 200, 1, 1, 1, 2);
    for (int f = 0; f < 3; f++) run_frame();
    repeat (2) drive(0, 5, 5, 1, 1, 1, 0);

    repeat (4) @(posedge clk);
    #2;
    total++;
    if (pix_q.size() != 0 || cnt_q.size() != 0) begin
      bad++;
      $display("FAIL leftover entries pix=%0d cnt=%0d want 0", pix_q.size(), cnt_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
